// File: rtl/rns2bin_mrc_32_31_21_5_pkg.sv
// rtl/rns2bin_mrc_32_31_21_5_pkg.sv - shared constants and state encoding for the (32,31,21,5) MRC converter
package rns_32_31_21_5_pkg;

  localparam int M1 = 32;
  localparam int M2 = 31;
  localparam int M3 = 21;
  localparam int M4 = 5;
  localparam int M  = 104160;

  localparam int INV32_M21 = 2;
  localparam int INV31_M21 = 19;
  localparam int INV32_M5  = 3;

  localparam int RES_W = 5;
  localparam int OUT_W = 17;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    A2   = 3'd1,
    A3   = 3'd2,
    A4   = 3'd3,
    ACC  = 3'd4,
    OUT  = 3'd5
  } state_t;

endpackage

// File: rtl/rns2bin_mrc_32_31_21_5_mod_sub_mul.sv
// rtl/rns2bin_mrc_32_31_21_5_mod_sub_mul.sv - combinational ((a-b) mod MOD) * INV mod MOD
module mod_sub_mul #(
  parameter int MOD = 21,
  parameter int INV = 1,
  parameter int W   = 5,
  parameter int OW  = $clog2(MOD)
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [OW-1:0] y
);

  localparam logic [W-1:0]    MOD_W = W'(MOD);
  localparam logic [OW-1:0]   MOD_O = OW'(MOD);
  localparam logic [OW-1:0]   INV_O = OW'(INV);
  localparam logic [2*OW-1:0] MOD_P = (2*OW)'(MOD);

  logic [OW-1:0]   ar;
  logic [OW-1:0]   br;
  logic [OW-1:0]   diff;
  logic [2*OW-1:0] prod;

  always_comb begin
    ar = OW'(a % MOD_W);
    br = OW'(b % MOD_W);
    // When ar < br the true value ar+MOD-br lies in [1,MOD-1], so wrap-around in OW bits is exact.
    diff = (ar >= br) ? (ar - br) : (ar + MOD_O - br);
    prod = {{OW{1'b0}}, diff} * {{OW{1'b0}}, INV_O};
    y    = OW'(prod % MOD_P);
  end

endmodule

// File: rtl/rns2bin_mrc_32_31_21_5.sv
// rtl/rns2bin_mrc_32_31_21_5.sv - sequential mixed-radix RNS(32,31,21,5) to binary converter
module rns2bin_mrc_32_31_21_5
  import rns_32_31_21_5_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] r1,
  input  logic [RES_W-1:0] r2,
  input  logic [RES_W-1:0] r3,
  input  logic [2:0]       r4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             out_err
);

  state_t           state;
  logic [RES_W-1:0] a1;
  logic [RES_W-1:0] rr2;
  logic [RES_W-1:0] rr3;
  logic [2:0]       rr4;
  logic [4:0]       a2;
  logic [4:0]       a3;
  logic [2:0]       a4;
  logic             err;

  logic [4:0]       a2_c;
  logic [4:0]       a3_t;
  logic [4:0]       a3_c;
  logic [2:0]       a4_t;
  logic [2:0]       a4_u;
  logic [2:0]       a4_c;
  logic [OUT_W-1:0] acc_t;
  logic [OUT_W-1:0] acc_u;
  logic [OUT_W-1:0] acc_x;

  mod_sub_mul #(.MOD(M2), .INV(1), .W(5)) u_a2 (
    .a(rr2), .b(a1), .y(a2_c)
  );

  mod_sub_mul #(.MOD(M3), .INV(INV32_M21), .W(5)) u_a3_t (
    .a(rr3), .b(a1), .y(a3_t)
  );

  mod_sub_mul #(.MOD(M3), .INV(INV31_M21), .W(5)) u_a3 (
    .a(a3_t), .b(a2), .y(a3_c)
  );

  mod_sub_mul #(.MOD(M4), .INV(INV32_M5), .W(5)) u_a4_t (
    .a({2'b00, rr4}), .b(a1), .y(a4_t)
  );

  mod_sub_mul #(.MOD(M4), .INV(1), .W(5)) u_a4_u (
    .a({2'b00, a4_t}), .b(a2), .y(a4_u)
  );

  mod_sub_mul #(.MOD(M4), .INV(1), .W(5)) u_a4 (
    .a({2'b00, a4_u}), .b(a3), .y(a4_c)
  );

  // Horner form: 21*t = 16t+4t+t, 31*u = 32u-u, 32*v = v<<5.
  always_comb begin
    acc_t = OUT_W'(a3) + (OUT_W'(a4) << 4) + (OUT_W'(a4) << 2) + OUT_W'(a4);
    acc_u = OUT_W'(a2) + (acc_t << 5) - acc_t;
    acc_x = OUT_W'(a1) + (acc_u << 5);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_err   <= 1'b0;
      a1        <= '0;
      rr2       <= '0;
      rr3       <= '0;
      rr4       <= '0;
      a2        <= '0;
      a3        <= '0;
      a4        <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a1       <= r1;
            rr2      <= r2;
            rr3      <= r3;
            rr4      <= r4;
            err      <= (r2 > 5'd30) || (r3 > 5'd20) || (r4 > 3'd4);
            in_ready <= 1'b0;
            state    <= A2;
          end else begin
            in_ready <= 1'b1;
          end
        end
        A2: begin
          a2    <= a2_c;
          state <= A3;
        end
        A3: begin
          a3    <= a3_c;
          state <= A4;
        end
        A4: begin
          a4    <= a4_c;
          state <= ACC;
        end
        ACC: begin
          result  <= err ? '0 : acc_x;
          out_err <= err;
          state   <= OUT;
        end
        OUT: begin
          // out_valid rises one cycle after entering OUT, giving the fixed five-clock latency.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rns2bin_mrc_32_31_21_5.sv
// tb/tb_rns2bin_mrc_32_31_21_5.sv - randomized self-checking bench for rns2bin_mrc_32_31_21_5
module tb_rns2bin_mrc_32_31_21_5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  r1 = '0;
  logic [4:0]  r2 = '0;
  logic [4:0]  r3 = '0;
  logic [2:0]  r4 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] result;
  logic        out_err;

  int n_vec = 0;
  int n_bad = 0;

  rns2bin_mrc_32_31_21_5 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one tuple through the block and reports what was observed; no checking here.
  task automatic do_txn(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input logic [2:0] d, input int hold, input bit rnd, input bit junk,
                        output logic [16:0] res, output logic err_o, output int lat,
                        output bit stable, output bit busy_low, output bit dropped, output bit ok);
    int n;
    bit rdy;
    ok = 1'b1; stable = 1'b1; busy_low = 1'b1; dropped = 1'b0;
    res = '0; err_o = 1'b0; lat = 0;
    r1 = a; r2 = b; r3 = c; r4 = d; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin in_valid = 1'b0; ok = 1'b0; return; end
    tick();
    if (junk) begin
      r1 = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom); r4 = 3'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    while (!out_valid && lat < 50) begin
      if (in_ready) busy_low = 1'b0;
      tick(); lat++;
    end
    if (!out_valid) begin in_valid = 1'b0; ok = 1'b0; return; end
    res = result; err_o = out_err;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 300) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : (n >= hold);
      if (rdy) in_valid = 1'b0;
      out_ready = rdy;
      if (!out_valid || result !== res || out_err !== err_o) stable = 1'b0;
      if (in_ready) busy_low = 1'b0;
      tick(); n++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    if (!rdy) begin ok = 1'b0; return; end
    dropped = !out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (result !== 17'd0) begin n_bad++; $display("FAIL reset_result got=%0d exp=0", result); end
    n_vec++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    reset = 1'b1;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [4:0]  ta [3] = '{5'd8, 5'd31, 5'd0};
    logic [4:0]  tb [3] = '{5'd8, 5'd30, 5'd0};
    logic [4:0]  tc [3] = '{5'd13, 5'd20, 5'd0};
    logic [2:0]  td [3] = '{3'd0, 3'd4, 3'd0};
    logic [16:0] tx [3] = '{17'd1000, 17'd104159, 17'd0};
    logic [16:0] res; logic e; int lat; bit st, bl, dr, ok;
    for (int i = 0; i < 3; i++) begin
      do_txn(ta[i], tb[i], tc[i], td[i], 0, 1'b0, 1'b0, res, e, lat, st, bl, dr, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL directed_timeout idx=%0d", i); continue; end
      n_vec++; if (res !== tx[i]) begin n_bad++; $display("FAIL directed_result idx=%0d got=%0d exp=%0d", i, res, tx[i]); end
      n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL directed_err idx=%0d got=%b exp=0", i, e); end
      n_vec++; if (lat != 5) begin n_bad++; $display("FAIL directed_latency idx=%0d got=%0d exp=5", i, lat); end
      n_vec++; if (!dr) begin n_bad++; $display("FAIL directed_valid_drop idx=%0d got=1 exp=0", i); end
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] res; logic e; int lat; bit st, bl, dr, ok, extra;
    do_txn(5'd31, 5'd1, 5'd15, 3'd0, 10, 1'b0, 1'b1, res, e, lat, st, bl, dr, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL backpressure_timeout"); return; end
    n_vec++; if (res !== 17'd65535) begin n_bad++; $display("FAIL backpressure_result got=%0d exp=65535", res); end
    n_vec++; if (!st) begin n_bad++; $display("FAIL backpressure_stable got=unstable exp=stable"); end
    n_vec++; if (!bl) begin n_bad++; $display("FAIL backpressure_in_ready got=1 exp=0"); end
    n_vec++; if (!dr) begin n_bad++; $display("FAIL backpressure_release got=1 exp=0"); end
    extra = 1'b0;
    repeat (10) begin tick(); if (out_valid) extra = 1'b1; end
    n_vec++; if (extra) begin n_bad++; $display("FAIL backpressure_junk_accepted got=1 exp=0"); end
  endtask

  task automatic test_err();
    logic [16:0] res; logic e; int lat; bit st, bl, dr, ok;
    do_txn(5'd3, 5'd31, 5'd5, 3'd2, 0, 1'b0, 1'b0, res, e, lat, st, bl, dr, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL err_timeout"); return; end
    n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_flag got=%b exp=1", e); end
    n_vec++; if (res !== 17'd0) begin n_bad++; $display("FAIL err_result got=%0d exp=0", res); end
  endtask

  task automatic test_mid_reset();
    logic [16:0] res; logic e; int lat; bit st, bl, dr, ok, seen;
    int n;
    r1 = 5'd8; r2 = 5'd8; r3 = 5'd13; r4 = 3'd0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (result !== 17'd0) begin n_bad++; $display("FAIL midreset_result got=%0d exp=0", result); end
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_in_ready got=%b exp=0", in_ready); end
    repeat (2) tick();
    reset = 1'b1;
    tick();
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_release_in_ready got=%b exp=1", in_ready); end
    seen = 1'b0;
    repeat (8) begin tick(); if (out_valid) seen = 1'b1; end
    n_vec++; if (seen) begin n_bad++; $display("FAIL midreset_ghost_output got=1 exp=0"); end
    do_txn(5'd8, 5'd8, 5'd13, 3'd0, 0, 1'b0, 1'b0, res, e, lat, st, bl, dr, ok);
    n_vec++; if (!ok || res !== 17'd1000 || e !== 1'b0) begin
      n_bad++; $display("FAIL midreset_next_txn got=%0d err=%b ok=%b exp=1000 err=0", res, e, ok);
    end
  endtask

  task automatic test_random();
    logic [16:0] res; logic e; int lat; bit st, bl, dr, ok, bad_in;
    int x;
    logic [4:0] a, b, c; logic [2:0] d;
    for (int i = 0; i < 1000; i++) begin
      x = int'($urandom_range(0, 104159));
      a = 5'(x % 32); b = 5'(x % 31); c = 5'(x % 21); d = 3'(x % 5);
      bad_in = ($urandom_range(0, 9) == 0);
      if (bad_in) c = 5'($urandom_range(21, 31));
      repeat ($urandom_range(0, 3)) tick();
      do_txn(a, b, c, d, 0, 1'b1, 1'b0, res, e, lat, st, bl, dr, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL random_timeout i=%0d", i); continue; end
      n_vec++; if (res !== (bad_in ? 17'd0 : 17'(x))) begin
        n_bad++; $display("FAIL random_result i=%0d got=%0d exp=%0d", i, res, bad_in ? 0 : x);
      end
      n_vec++; if (e !== bad_in) begin n_bad++; $display("FAIL random_err i=%0d got=%b exp=%b", i, e, bad_in); end
      n_vec++; if (lat != 5 || !st || !dr) begin
        n_bad++; $display("FAIL random_protocol i=%0d lat=%0d stable=%b dropped=%b exp=5/1/1", i, lat, st, dr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_err();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
